// File: rtl/irq_controller_mc_if.sv
// Bus bundle between the interrupt controller and the core/CSR/trap logic.
// The core side uses the master modport, the controller uses the slave modport.
interface irq_controller_mc_if #(
  parameter int N_IRQ = 16,
  parameter int IDW   = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
);
  logic             exception_i;
  logic [N_IRQ-1:0] irq_req_i;
  logic             mie_i;
  logic [N_IRQ-1:0] mask_i;
  logic             mret_i;
  logic             irq_o;
  logic [IDW-1:0]   irq_id_o;
  logic [31:0]      irq_cause_o;
  logic             irq_ret_o;
  logic [N_IRQ-1:0] irq_pending_o;

  modport master (
    output exception_i, irq_req_i, mie_i, mask_i, mret_i,
    input  irq_o, irq_id_o, irq_cause_o, irq_ret_o, irq_pending_o
  );

  modport slave (
    input  exception_i, irq_req_i, mie_i, mask_i, mret_i,
    output irq_o, irq_id_o, irq_cause_o, irq_ret_o, irq_pending_o
  );
endinterface

// File: rtl/irq_controller_mc.sv
// N_IRQ-source prioritised interrupt controller with handler-context tracking.
// Define IRQ_EDGE_EN to enable edge capture for sources selected by EDGE_MASK.
module irq_controller_mc #(
  parameter int               N_IRQ      = 16,
  parameter logic [31:0]      CAUSE_BASE = 32'h1000_0010,
  parameter logic [N_IRQ-1:0] EDGE_MASK  = '0,
  parameter int               IDW        = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input logic               clk_i,
  input logic               rst_i,
  irq_controller_mc_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IRQ     = 2'd1,
    ST_EXC     = 2'd2,
    ST_IRQ_EXC = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   active_id_q, active_id_d;
  logic [N_IRQ-1:0] pend_s;
  logic [N_IRQ-1:0] elig_s;
  logic [IDW-1:0]   win_id_s;
  logic             take_s;
  logic             ret_s;

`ifdef IRQ_EDGE_EN
  logic [N_IRQ-1:0] prev_q, prev_d;
  logic [N_IRQ-1:0] epend_q, epend_d;
  logic [N_IRQ-1:0] take_vec_s;

  // Edge sources read their capture register, level sources read the line.
  always_comb begin
    pend_s = (epend_q & EDGE_MASK) | (bus.irq_req_i & ~EDGE_MASK);
  end

  // Edge capture: a new rising edge wins over the clear from being taken.
  always_comb begin
    take_vec_s = {N_IRQ{1'b0}};
    for (int k = 0; k < N_IRQ; k++) begin
      take_vec_s[k] = take_s && (win_id_s == IDW'(k));
    end
    prev_d  = bus.irq_req_i & EDGE_MASK;
    epend_d = ((epend_q & ~take_vec_s) | (bus.irq_req_i & ~prev_q)) & EDGE_MASK;
  end

  // Edge capture registers.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      prev_q  <= {N_IRQ{1'b0}};
      epend_q <= {N_IRQ{1'b0}};
    end else begin
      prev_q  <= prev_d;
      epend_q <= epend_d;
    end
  end
`else
  // Without edge capture every source is level-sensitive.
  localparam logic [N_IRQ-1:0] LVL_SEL = ~(EDGE_MASK & {N_IRQ{1'b0}});

  // Pending vector is the raw request vector.
  always_comb begin
    pend_s = bus.irq_req_i & LVL_SEL;
  end
`endif

  // Eligibility and fixed priority: lowest index wins.
  always_comb begin
    elig_s   = pend_s & bus.mask_i;
    win_id_s = {IDW{1'b0}};
    for (int k = N_IRQ - 1; k >= 0; k--) begin
      win_id_s = elig_s[k] ? IDW'(k) : win_id_s;
    end
  end

  // Context FSM; exceptions outrank both returns and new interrupts.
  always_comb begin
    state_d     = state_q;
    active_id_d = active_id_q;
    take_s      = 1'b0;
    ret_s       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.exception_i) begin
          state_d = ST_EXC;
        end else if (rst_i && bus.mie_i && (|elig_s)) begin
          take_s      = 1'b1;
          active_id_d = win_id_s;
          state_d     = ST_IRQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_IRQ: begin
        if (bus.exception_i) begin
          state_d = ST_IRQ_EXC;
        end else if (bus.mret_i) begin
          ret_s   = rst_i;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_IRQ;
        end
      end
      ST_EXC: begin
        if (bus.mret_i && !bus.exception_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_EXC;
        end
      end
      ST_IRQ_EXC: begin
        if (bus.mret_i && !bus.exception_i) begin
          state_d = ST_IRQ;
        end else begin
          state_d = ST_IRQ_EXC;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Context state and active source id.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      active_id_q <= {IDW{1'b0}};
    end else begin
      state_q     <= state_d;
      active_id_q <= active_id_d;
    end
  end

  // Output path is purely combinational so level requests are taken in-cycle.
  always_comb begin
    bus.irq_o         = take_s;
    bus.irq_ret_o     = ret_s;
    bus.irq_id_o      = take_s ? win_id_s : active_id_q;
    bus.irq_cause_o   = CAUSE_BASE + {{(32 - IDW){1'b0}}, bus.irq_id_o};
    bus.irq_pending_o = pend_s;
  end

endmodule

// File: tb/tb_irq_controller_mc.sv
// Randomised bench for irq_controller_mc against a handler-stack reference model.
// Honours IRQ_EDGE_EN the same way as the design.
module tb_irq_controller_mc;
  localparam int          N   = 16;
  localparam int          IDW = 4;
  localparam logic [15:0] EM  = 16'h0F04;
  localparam logic [31:0] CB  = 32'h1000_0010;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk  = 0;
  int   n_pass = 0;

  irq_controller_mc_if #(.N_IRQ(N), .IDW(IDW)) bus ();

  irq_controller_mc #(.N_IRQ(N), .CAUSE_BASE(CB), .EDGE_MASK(EM), .IDW(IDW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: handler context as a stack of frames (1 = interrupt, 2 = exception).
  int          stk[$];
  int          act_id = 0;
  logic [15:0] epend  = 16'h0000;
  logic [15:0] prev   = 16'h0000;
  logic [15:0] edge_sel;

  logic        obs_irq, obs_ret;
  logic [31:0] obs_id, obs_cause;
  logic [15:0] obs_pend;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic cycle(input logic [15:0] req, input logic mie, input logic [15:0] mask,
                       input logic exc, input logic mret, input logic rst_v);
    logic [15:0] pend_m, elig;
    int          win;
    bit          take, ret;
    int          exp_id;
    @(negedge clk);
    bus.irq_req_i   = req;
    bus.mie_i       = mie;
    bus.mask_i      = mask;
    bus.exception_i = exc;
    bus.mret_i      = mret;
    rst             = rst_v;
    #1;
    obs_irq   = bus.irq_o;
    obs_ret   = bus.irq_ret_o;
    obs_id    = 32'(bus.irq_id_o);
    obs_cause = bus.irq_cause_o;
    obs_pend  = bus.irq_pending_o;

    pend_m = (epend & edge_sel) | (req & ~edge_sel);
    elig   = pend_m & mask;
    win    = -1;
    for (int k = 0; k < N; k++) if (win < 0 && elig[k]) win = k;
    take   = rst_v && (stk.size() == 0) && !exc && mie && (win >= 0);
    ret    = rst_v && !exc && mret && (stk.size() > 0) && (stk[$] == 1);
    exp_id = take ? win : act_id;

    chk("irq_o", 32'(obs_irq), 32'(take));
    chk("irq_ret_o", 32'(obs_ret), 32'(ret));
    chk("irq_id_o", obs_id, 32'(exp_id));
    chk("irq_cause_o", obs_cause, CB + 32'(exp_id));
    chk("irq_pending_o", 32'(obs_pend), 32'(pend_m));

    if (!rst_v) begin
      stk.delete();
      act_id = 0;
      epend  = 16'h0000;
      prev   = 16'h0000;
    end else begin
      if (exc) begin
        if (stk.size() == 0 || stk[$] == 1) stk.push_back(2);
      end else if (mret && stk.size() > 0) begin
        void'(stk.pop_back());
      end else if (take) begin
        stk.push_back(1);
        act_id = win;
      end
      for (int k = 0; k < N; k++) begin
        if (edge_sel[k]) begin
          if (req[k] && !prev[k]) epend[k] = 1'b1;
          else if (take && win == k) epend[k] = 1'b0;
        end
      end
      prev = req & edge_sel;
    end
  endtask

  initial begin
`ifdef IRQ_EDGE_EN
    edge_sel = EM;
`else
    edge_sel = 16'h0000;
`endif
    bus.irq_req_i = 16'h0000; bus.mie_i = 1'b0; bus.mask_i = 16'h0000;
    bus.exception_i = 1'b0; bus.mret_i = 1'b0;

    cycle(16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    cycle(16'h0028, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0);
    chk("rst_irq_low", 32'(obs_irq), 32'd0);
    chk("rst_ret_low", 32'(obs_ret), 32'd0);

    // Level priority.
    cycle(16'h0028, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1);
    chk("lvl_irq", 32'(obs_irq), 32'd1);
    chk("lvl_id3", obs_id, 32'd3);
    chk("lvl_cause", obs_cause, 32'h1000_0013);
    cycle(16'h0028, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1);
    chk("lvl_one_shot", 32'(obs_irq), 32'd0);
    cycle(16'h0000, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b1);
    chk("lvl_ret", 32'(obs_ret), 32'd1);

    // Exception beats interrupt, then source 0 is taken.
    cycle(16'h0001, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1);
    chk("exc_blocks_irq", 32'(obs_irq), 32'd0);
    cycle(16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b1);
    chk("exc_no_ret", 32'(obs_ret), 32'd0);
    cycle(16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1);
    chk("after_exc_take", 32'(obs_irq), 32'd1);
    chk("after_exc_id0", obs_id, 32'd0);
    cycle(16'h0000, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b1);

    // Exception nested inside interrupt 5.
    cycle(16'h0020, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1);
    chk("nest_id5", obs_id, 32'd5);
    cycle(16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1);
    cycle(16'h0000, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b1);
    chk("nest_no_ret", 32'(obs_ret), 32'd0);
    chk("nest_cause", obs_cause, 32'h1000_0015);
    cycle(16'h0000, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b1);
    chk("nest_ret", 32'(obs_ret), 32'd1);

    // Mask and global gating on line 7.
    cycle(16'h0080, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk("masked", 32'(obs_irq), 32'd0);
    cycle(16'h0080, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1);
    chk("mie_off", 32'(obs_irq), 32'd0);
    cycle(16'h0080, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1);
    chk("unmask_id7", obs_id, 32'd7);
    cycle(16'h0000, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b1);

`ifdef IRQ_EDGE_EN
    // Edge capture on line 2.
    cycle(16'h0004, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1);
    cycle(16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1);
    chk("edge_held", 32'(obs_pend[2]), 32'd1);
    cycle(16'h0000, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1);
    chk("edge_take_id2", obs_id, 32'd2);
    chk("edge_take", 32'(obs_irq), 32'd1);
    cycle(16'h0000, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1);
    chk("edge_cleared", 32'(obs_pend[2]), 32'd0);
    cycle(16'h0000, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b1);
`endif

    // Reset in the middle of a handler.
    cycle(16'h0080, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1);
    cycle(16'h0080, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0);
    chk("rst_mid_ret", 32'(obs_ret), 32'd0);
    chk("rst_mid_irq", 32'(obs_irq), 32'd0);
    cycle(16'h0000, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b1);
    chk("rst_mid_idle", 32'(obs_ret), 32'd0);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle(16'($urandom & $urandom & $urandom),
            ($urandom_range(3) != 0),
            16'($urandom | $urandom),
            ($urandom_range(7) == 0),
            ($urandom_range(3) == 0),
            ($urandom_range(63) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/irq_controller_mc.md
# irq_controller_mc

Parametrised multi-source interrupt controller for the RISC-V core; generalises the single-line controller to N_IRQ prioritised sources with per-source masking and optional edge capture. It sits between external interrupt lines, the CSR unit, and the trap/PC logic. It tracks the handler context (interrupt, exception, or exception nested in an interrupt) and drives the trap request, cause, and return signals.

## Interface
- N_IRQ, 16: number of interrupt sources, 1..32.
- CAUSE_BASE, 32'h1000_0010: cause value for source 0; source k reports CAUSE_BASE + k.
- EDGE_MASK, '0 (N_IRQ bits): bit k = 1 makes source k edge-sensitive. Only used with IRQ_EDGE_EN.
- IDW, derived: max(1, $clog2(N_IRQ)).

- clk_i, in, 1: the single clock.
- rst_i, in, 1: synchronous, active-low reset.
- exception_i, in, 1: synchronous exception from the core.
- irq_req_i, in, N_IRQ: raw interrupt lines.
- mie_i, in, 1: global interrupt enable.
- mask_i, in, N_IRQ: per-source enable.
- mret_i, in, 1: MRET executed.
- irq_o, out, 1: take interrupt now.
- irq_id_o, out, IDW: winning or active source index.
- irq_cause_o, out, 32: CAUSE_BASE + irq_id_o.
- irq_ret_o, out, 1: return from interrupt handler.
- irq_pending_o, out, N_IRQ: current pending vector, for CSR mip reads.

## Operation
- Pending vector:
  - Level source k: pend[k] = irq_req_i[k].
  - Edge source k: pend[k] is a register. It sets on a rising edge (irq_req_i[k] & ~prev[k]) and clears in the cycle source k is taken. If set and clear coincide, set wins.
- Eligibility: elig = pend & mask_i.
- Winner: lowest-index set bit of elig (index 0 has the highest priority).
- States: IDLE, IRQ, EXC, IRQ_EXC.
- IDLE:
  - exception_i -> EXC. No interrupt is taken that cycle; pending bits are kept.
  - Otherwise, if mie_i & |elig: irq_o = 1, the winner id is latched into the active-id register, and the state goes to IRQ.
- IRQ:
  - exception_i -> IRQ_EXC.
  - Else mret_i -> irq_ret_o = 1, state goes to IDLE.
  - No new interrupt is taken while in IRQ; no preemption.
- EXC: mret_i & ~exception_i -> IDLE, with irq_ret_o = 0.
- IRQ_EXC: mret_i & ~exception_i -> IRQ, with irq_ret_o = 0.
- Exception re-entry: exception_i in EXC or IRQ_EXC keeps the current state.
- Simultaneous events:
  - exception_i beats mret_i; no return occurs.
  - exception_i beats any interrupt request.
- irq_id_o: winner id while irq_o = 1, otherwise the active-id register.
- irq_cause_o: always CAUSE_BASE + irq_id_o, computed with 32-bit unsigned addition and the id zero-extended.

## Timing
- irq_o, irq_ret_o, irq_id_o and irq_cause_o are combinational from state, registers and inputs. There is no register on the output path.
- irq_o is high for exactly one cycle per taken interrupt; the next cycle is in IRQ.
- Latency, level source: request to irq_o is 0 cycles.
- Latency, edge source: rising edge to irq_o is 1 cycle, because pend registers at the edge.
- State, pend, prev and active id update on the posedge of clk_i.
- Reset (rst_i = 0 at a clock edge):
  - state = IDLE; pend = 0; prev = 0; active id = 0.
  - While rst_i = 0, irq_o = 0 and irq_ret_o = 0.
  - Reset mid-handler discards context; no irq_ret_o is produced.
- Because prev resets to 0, an edge line that is high at reset release registers one edge.
- Masking an edge source keeps its pending bit; it is taken once unmasked.
- Masking a level source drops it immediately.

## Configuration
- IRQ_EDGE_EN defined: EDGE_MASK is honoured; the prev and pend registers exist for edge sources.
- IRQ_EDGE_EN undefined:
  - All sources are level-sensitive and EDGE_MASK is ignored.
  - No edge registers exist; irq_pending_o = irq_req_i.

## Test plan
- Level priority: N_IRQ = 16, mie_i = 1, mask_i = 16'hFFFF, irq_req_i = 16'h0028 in IDLE -> same cycle irq_o = 1, irq_id_o = 3, irq_cause_o = 32'h1000_0013. Next cycle irq_o = 0. mret_i -> irq_ret_o = 1, state IDLE.
- Exception wins: exception_i = 1 together with irq_req_i[0] = 1 -> irq_o = 0, state EXC. mret_i -> irq_ret_o = 0, IDLE. The next cycle takes source 0.
- Nested exception: in IRQ with id 5, exception_i pulse, then mret_i -> irq_ret_o = 0, state IRQ, irq_cause_o stays 32'h1000_0015. A second mret_i -> irq_ret_o = 1.
- Edge capture (IRQ_EDGE_EN, EDGE_MASK[2] = 1): one-cycle pulse on line 2 with mie_i = 0 -> irq_pending_o[2] stays 1. Setting mie_i = 1 -> irq_o with id 2, and pend[2] clears the next cycle.
- Mask and global gating: mask_i = 0 or mie_i = 0 with line 7 high -> irq_o never asserts. Unmasking -> irq_o with id 7.
- Reset mid-handler: in IRQ, drive rst_i = 0 for one edge -> IDLE, pending cleared, irq_ret_o = 0, irq_o = 0 during reset.
